// File: rtl/blinds_motor_ctrl_if.sv
// blinds_motor_ctrl_if
// Carries the level-code command handshake and the motion status of the
// roller-blind motor controller.
//   a, b        : level code {a,b}, 00 closed .. 11 fully open (master -> slave)
//   req         : command request, sampled every cycle          (master -> slave)
//   stop        : emergency stop, level-sensitive                (master -> slave)
//   ack         : one-cycle pulse, command accepted              (slave -> master)
//   done        : one-cycle pulse, target position reached       (slave -> master)
//   busy        : controller is not idle                         (slave -> master)
//   motor_up    : motor drives the blind open                    (slave -> master)
//   motor_down  : motor drives the blind closed                  (slave -> master)
//   pos[7:0]    : current blind position, 0 = closed             (slave -> master)
interface blinds_motor_ctrl_if;
  logic       a;
  logic       b;
  logic       req;
  logic       stop;
  logic       ack;
  logic       done;
  logic       busy;
  logic       motor_up;
  logic       motor_down;
  logic [7:0] pos;

  modport master (
    output a, b, req, stop,
    input  ack, done, busy, motor_up, motor_down, pos
  );

  modport slave (
    input  a, b, req, stop,
    output ack, done, busy, motor_up, motor_down, pos
  );
endinterface

// File: rtl/blinds_motor_ctrl.sv
// blinds_motor_ctrl
// Runs the roller-blind motor up or down until the step-counted position
// matches the level requested over the req/ack handshake.
// Ports:
//   clk  : single clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : blinds_motor_ctrl_if.slave (a, b, req, stop in; ack, done, busy,
//          motor_up, motor_down, pos out)
// Parameters:
//   STEPS_PER_QUARTER : position steps per quarter of travel (1..63)
//   STEP_DIV          : clock cycles per position step while moving (2..255)
//   DEAD_CYCLES       : motor-off cycles on a reversal (1..255), only present
//                       when BLINDS_DEADTIME_EN is defined
// Optional feature: define BLINDS_DEADTIME_EN to insert a BRAKE phase on
// direction reversals; without it the motor reverses directly.
module blinds_motor_ctrl #(
  parameter int STEPS_PER_QUARTER = 16,
  parameter int STEP_DIV          = 4
`ifdef BLINDS_DEADTIME_EN
  ,
  parameter int DEAD_CYCLES       = 3
`endif
) (
  input logic                clk,
  input logic                rst,
  blinds_motor_ctrl_if.slave bus
);

  localparam logic [7:0] QUARTER  = 8'(STEPS_PER_QUARTER);
  localparam logic [7:0] DIV_LAST = 8'(STEP_DIV - 1);
`ifdef BLINDS_DEADTIME_EN
  localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYCLES - 1);
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    UP    = 2'd1,
`ifdef BLINDS_DEADTIME_EN
    DOWN  = 2'd2,
    BRAKE = 2'd3
`else
    DOWN  = 2'd2
`endif
  } state_t;

  state_t     state, state_next, want;
  logic [7:0] pos, pos_next, pos_step;
  logic [7:0] target, target_next, req_target, eff_target;
  logic [7:0] div, div_next;
  logic       ack_q, ack_next;
  logic       done_q, done_next;
  logic       step;
`ifdef BLINDS_DEADTIME_EN
  logic [7:0] brake_cnt, brake_next;
`endif

  // Level code to absolute position; fully open is a full four quarters.
  function automatic logic [7:0] level_target(input logic [1:0] code);
    case (code)
      2'b00:   return 8'd0;
      2'b01:   return QUARTER;
      2'b10:   return QUARTER << 1;
      default: return QUARTER << 2;
    endcase
  endfunction

  // State and datapath registers. Reset drops the state to IDLE at once,
  // which turns both motors off without waiting for a clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      pos       <= '0;
      target    <= '0;
      div       <= '0;
      ack_q     <= 1'b0;
      done_q    <= 1'b0;
`ifdef BLINDS_DEADTIME_EN
      brake_cnt <= '0;
`endif
    end else begin
      state     <= state_next;
      pos       <= pos_next;
      target    <= target_next;
      div       <= div_next;
      ack_q     <= ack_next;
      done_q    <= done_next;
`ifdef BLINDS_DEADTIME_EN
      brake_cnt <= brake_next;
`endif
    end
  end

  // Next-state logic. A prescaler step that falls on the same edge as a
  // retarget is applied first, and the new target is compared against the
  // stepped position, so the blind never overshoots and never misses arrival.
  // Stop is evaluated last so that it overrides any accepted request.
  always_comb begin
    state_next  = state;
    pos_next    = pos;
    target_next = target;
    div_next    = div;
    ack_next    = 1'b0;
    done_next   = 1'b0;
`ifdef BLINDS_DEADTIME_EN
    brake_next  = brake_cnt;
`endif

    step     = ((state == UP) || (state == DOWN)) && (div == DIV_LAST);
    pos_step = pos;
    if (step) begin
      pos_step = (state == UP) ? pos + 8'd1 : pos - 8'd1;
    end

    req_target = level_target({bus.a, bus.b});
    eff_target = target;
    if (bus.req) begin
      eff_target  = req_target;
      target_next = req_target;
      ack_next    = 1'b1;
    end
    want = (eff_target > pos_step) ? UP : DOWN;

    case (state)
      IDLE: begin
        if (bus.req) begin
          if (eff_target == pos) begin
            done_next = 1'b1;
          end else begin
            state_next = want;
            div_next   = '0;
          end
        end
      end
      UP, DOWN: begin
        pos_next = pos_step;
        div_next = step ? 8'd0 : div + 8'd1;
        if (eff_target == pos_step) begin
          state_next = IDLE;
          done_next  = 1'b1;
          div_next   = '0;
        end else if (want != state) begin
`ifdef BLINDS_DEADTIME_EN
          state_next = BRAKE;
          brake_next = DEAD_LAST;
`else
          state_next = want;
`endif
          div_next   = '0;
        end
      end
`ifdef BLINDS_DEADTIME_EN
      // Direction is chosen only at BRAKE exit, so retargets made while
      // braking simply update the target.
      BRAKE: begin
        if (brake_cnt == 8'd0) begin
          div_next = '0;
          if (eff_target == pos) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else begin
            state_next = want;
          end
        end else begin
          brake_next = brake_cnt - 8'd1;
        end
      end
`endif
      default: state_next = IDLE;
    endcase

    if (bus.stop) begin
      state_next  = IDLE;
      pos_next    = pos;
      target_next = pos;
      div_next    = '0;
      ack_next    = 1'b0;
      done_next   = 1'b0;
`ifdef BLINDS_DEADTIME_EN
      brake_next  = '0;
`endif
    end
  end

  // Motor drives are decoded from the state alone, so they can never be
  // high together and are off in IDLE and BRAKE.
  assign bus.motor_up   = (state == UP);
  assign bus.motor_down = (state == DOWN);
  assign bus.busy       = (state != IDLE);
  assign bus.ack        = ack_q;
  assign bus.done       = done_q;
  assign bus.pos        = pos;

endmodule
